// File: rtl/lynx_tpg_pkg.sv
// Shared beat-layout package for the traffic generator / checker pair.
// Holds the ID field width, the sequence-width helper, a default-sized
// beat struct, and the per-beat check result encoding.
// Ports: none (package).
package lynx_tpg_pkg;

    localparam int ID_WIDTH = 8;

    // Sequence field width left over once src, dst and id are packed.
    function automatic int seq_width(input int width, input int addr_width);
        return width - 2 * addr_width - ID_WIDTH;
    endfunction

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_SEQ_WIDTH  = seq_width(DEF_WIDTH, DEF_ADDR_WIDTH);

    // Default beat layout, MSB first: {src, dst, id, seq}.
    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] src;
        logic [DEF_ADDR_WIDTH-1:0] dst;
        logic [ID_WIDTH-1:0]       id;
        logic [DEF_SEQ_WIDTH-1:0]  seq;
    } beat_t;

    typedef enum logic [1:0] {
        CHK_OK        = 2'd0,
        CHK_ROUTE_ERR = 2'd1,
        CHK_SEQ_ERR   = 2'd2
    } chk_result_e;

endpackage

// File: rtl/tpc_seq_checker_if.sv
// Beat stream between a NoC output port and the traffic checker.
// Ports:
//   data_in   beat payload {src, dst, id, seq}
//   valid_in  payload valid
//   ready_out sink can accept this cycle
// master drives data/valid, slave (the checker) drives ready.
interface tpc_seq_checker_if
    import lynx_tpg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/tpc_ready_shaper.sv
// Programmable back-pressure source for the checker.
// A period counter runs 0..READY_PERIOD-1; ready is high for the first
// READY_PERIOD-READY_LOW counts and low for the last READY_LOW.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   ready     registered ready, 0 in reset, 1 on the first cycle after release
module tpc_ready_shaper #(
    parameter int READY_PERIOD = 1,
    parameter int READY_LOW    = 0
) (
    input  logic clk,
    input  logic rst,
    output logic ready
);

    localparam int CW = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
    localparam int HW = CW + 1;
    localparam logic [CW-1:0] LAST_CNT   = CW'(READY_PERIOD - 1);
    localparam logic [HW-1:0] HIGH_COUNT = HW'(READY_PERIOD - READY_LOW);

    if (READY_PERIOD < 1 || READY_LOW < 0 || READY_LOW >= READY_PERIOD) begin : g_bad_params
        $error("tpc_ready_shaper: need 0 <= READY_LOW < READY_PERIOD");
    end

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            ready <= ({1'b0, cnt} < HIGH_COUNT);
            cnt   <= (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tpc_seq_checker.sv
// Traffic sink/checker at a NoC output port.
// Per source it verifies that dst is this node and that seq advances by
// exactly one (mod 2^S); misrouted beats never touch the source table.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus           beat stream (slave): data_in, valid_in, ready_out
//   rx_count      accepted beats, wraps
//   err_count     route + sequence errors, saturates at 16'hFFFF
//   seq_err       1-cycle pulse, sequence error
//   route_err     1-cycle pulse, dst != NODE
//   err_sticky    set by any error until reset
//   last_err_src  src of the most recent erroring beat
//   done          sticky, rx_count reached EXPECT_COUNT (never if 0)
module tpc_seq_checker
    import lynx_tpg_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int N            = 16,
    parameter int N_ADDR_WIDTH = $clog2(N),
    parameter int NODE         = 15,
    parameter int READY_PERIOD = 1,
    parameter int READY_LOW    = 0,
    parameter int EXPECT_COUNT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    tpc_seq_checker_if.slave        bus,
    output logic [31:0]             rx_count,
    output logic [15:0]             err_count,
    output logic                    seq_err,
    output logic                    route_err,
    output logic                    err_sticky,
    output logic [N_ADDR_WIDTH-1:0] last_err_src,
    output logic                    done
);

    localparam int A = N_ADDR_WIDTH;
    localparam int S = seq_width(WIDTH, A);
    localparam logic [A-1:0] NODE_ADDR = A'(NODE);
    localparam logic [31:0]  EXPECT_W  = 32'(EXPECT_COUNT);

    if (S < 1) begin : g_bad_width
        $error("tpc_seq_checker: WIDTH too small for src/dst/id/seq layout");
    end

    typedef struct packed {
        logic [A-1:0]        src;
        logic [A-1:0]        dst;
        logic [ID_WIDTH-1:0] id;
        logic [S-1:0]        seq;
    } rx_beat_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic ready;

    tpc_ready_shaper #(
        .READY_PERIOD (READY_PERIOD),
        .READY_LOW    (READY_LOW)
    ) u_ready_shaper (
        .clk   (clk),
        .rst   (rst),
        .ready (ready)
    );

    assign bus.ready_out = ready;

    // ---- stage p0: unpack, table lookup, classify ----
    rx_beat_t    beat_p0;
    logic        vld_p0;
    logic        src_in_table_p0;
    logic        ent_vld_p0;
    logic [S-1:0] ent_exp_p0;
    logic [S-1:0] next_exp_p0;
    chk_result_e result_p0;
    logic        tbl_wr_p0;
    logic [31:0] rx_count_nxt_p0;
    logic        unused_id;

    logic [N-1:0] tbl_vld;
    logic [S-1:0] tbl_exp [N];

    assign beat_p0         = rx_beat_t'(bus.data_in);
    assign unused_id       = ^beat_p0.id;
    assign vld_p0          = bus.valid_in && ready;
    // Sources beyond N (non-power-of-two N) have no entry and always seed.
    assign src_in_table_p0 = (int'(beat_p0.src) < N);
    assign ent_vld_p0      = src_in_table_p0 && tbl_vld[beat_p0.src];
    assign ent_exp_p0      = tbl_exp[beat_p0.src];
    assign next_exp_p0     = beat_p0.seq + S'(1);
    assign rx_count_nxt_p0 = rx_count + 32'(vld_p0);

    always_comb begin
        result_p0 = CHK_OK;
        tbl_wr_p0 = 1'b0;
        if (vld_p0) begin
            if (beat_p0.dst != NODE_ADDR) begin
                result_p0 = CHK_ROUTE_ERR;
            end else begin
                // Seed, in-order and resync all store seq+1.
                tbl_wr_p0 = src_in_table_p0;
                if (ent_vld_p0 && (beat_p0.seq != ent_exp_p0)) begin
                    result_p0 = CHK_SEQ_ERR;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_vld <= '0;
        end else if (tbl_wr_p0) begin
            tbl_vld[beat_p0.src] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_wr_p0) begin
            tbl_exp[beat_p0.src] <= next_exp_p0;
        end
    end

    // ---- stage p1: registered pulses, counters, flags ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_count     <= '0;
            err_count    <= '0;
            seq_err      <= 1'b0;
            route_err    <= 1'b0;
            err_sticky   <= 1'b0;
            last_err_src <= '0;
            done         <= 1'b0;
        end else begin
            rx_count  <= rx_count_nxt_p0;
            seq_err   <= (result_p0 == CHK_SEQ_ERR);
            route_err <= (result_p0 == CHK_ROUTE_ERR);
            if (result_p0 != CHK_OK) begin
                err_count    <= sat_inc16(err_count);
                err_sticky   <= 1'b1;
                last_err_src <= beat_p0.src;
            end
            if ((EXPECT_COUNT != 0) && (rx_count_nxt_p0 >= EXPECT_W)) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tpc_seq_checker.sv
// Bench for tpc_seq_checker: two instances (always-ready, and 3-of-4
// back-pressure) driven with directed beats, a per-source expected-seq
// model compared every cycle, plus hand-computed literal expectations.
module tb_tpc_seq_checker;
    import lynx_tpg_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tpc_seq_checker_if #(.WIDTH(32)) a_if ();
    tpc_seq_checker_if #(.WIDTH(32)) b_if ();

    logic [31:0] a_rx, b_rx;
    logic [15:0] a_err, b_err;
    logic        a_seqe, b_seqe, a_route, b_route, a_sticky, b_sticky, a_done, b_done;
    logic [3:0]  a_last, b_last;

    tpc_seq_checker #(.WIDTH(32), .N(16), .N_ADDR_WIDTH(4), .NODE(5),
                      .READY_PERIOD(1), .READY_LOW(0), .EXPECT_COUNT(1)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if),
        .rx_count(a_rx), .err_count(a_err), .seq_err(a_seqe), .route_err(a_route),
        .err_sticky(a_sticky), .last_err_src(a_last), .done(a_done));

    tpc_seq_checker #(.WIDTH(32), .N(16), .N_ADDR_WIDTH(4), .NODE(5),
                      .READY_PERIOD(4), .READY_LOW(1), .EXPECT_COUNT(6)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if),
        .rx_count(b_rx), .err_count(b_err), .seq_err(b_seqe), .route_err(b_route),
        .err_sticky(b_sticky), .last_err_src(b_last), .done(b_done));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          P_ [2] = '{1, 4};
    int          L_ [2] = '{0, 1};
    int          E_ [2] = '{1, 6};
    int unsigned m_rx [2];
    int          m_err [2];
    bit          m_seqp [2], m_routep [2], m_sticky [2], m_done [2], m_ready [2];
    int          m_last [2];
    int          m_k [2];
    bit          m_tv [2][16];
    int          m_te [2][16];
    bit          m_live = 1'b0;

    task automatic note_err(input int d, input int src);
        if (m_err[d] < 65535) m_err[d]++;
        m_sticky[d] = 1'b1;
        m_last[d]   = src;
    endtask

    task automatic model_step(input int d, input logic v, input logic [31:0] w);
        int src, dst, seq;
        if (rst) begin
            m_rx[d] = 0; m_err[d] = 0; m_seqp[d] = 0; m_routep[d] = 0;
            m_sticky[d] = 0; m_done[d] = 0; m_ready[d] = 0; m_last[d] = 0; m_k[d] = 0;
            for (int i = 0; i < 16; i++) m_tv[d][i] = 1'b0;
            m_live = 1'b1;
        end else begin
            m_seqp[d]   = 1'b0;
            m_routep[d] = 1'b0;
            if (v === 1'b1 && m_ready[d]) begin
                src = int'(w[31:28]);
                dst = int'(w[27:24]);
                seq = int'(w[15:0]);
                m_rx[d]++;
                if (dst != 5) begin
                    m_routep[d] = 1'b1;
                    note_err(d, src);
                end else begin
                    if (m_tv[d][src] && seq != m_te[d][src]) begin
                        m_seqp[d] = 1'b1;
                        note_err(d, src);
                    end
                    m_tv[d][src] = 1'b1;
                    m_te[d][src] = (seq + 1) % 65536;
                end
            end
            if (E_[d] != 0 && m_rx[d] >= int'(E_[d])) m_done[d] = 1'b1;
            m_ready[d] = (m_k[d] % P_[d]) < (P_[d] - L_[d]);
            m_k[d]++;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, a_if.valid_in, a_if.data_in);
        model_step(1, b_if.valid_in, b_if.data_in);
    end

    task automatic cmp_outputs(input int d, input logic rdy, input logic [31:0] rx,
                               input logic [15:0] err, input logic se, input logic re,
                               input logic st, input logic [3:0] last, input logic dn);
        string p;
        p = (d == 0) ? "a" : "b";
        check({p, ".ready_out"},    32'(rdy),  32'(m_ready[d]));
        check({p, ".rx_count"},     rx,        m_rx[d]);
        check({p, ".err_count"},    32'(err),  32'(m_err[d]));
        check({p, ".seq_err"},      32'(se),   32'(m_seqp[d]));
        check({p, ".route_err"},    32'(re),   32'(m_routep[d]));
        check({p, ".err_sticky"},   32'(st),   32'(m_sticky[d]));
        check({p, ".last_err_src"}, 32'(last), 32'(m_last[d]));
        check({p, ".done"},         32'(dn),   32'(m_done[d]));
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            cmp_outputs(0, a_if.ready_out, a_rx, a_err, a_seqe, a_route, a_sticky, a_last, a_done);
            cmp_outputs(1, b_if.ready_out, b_rx, b_err, b_seqe, b_route, b_sticky, b_last, b_done);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] pack(input int src, input int dst, input int seq);
        logic [3:0]  s4, d4;
        logic [15:0] q16;
        s4  = 4'(src);
        d4  = 4'(dst);
        q16 = 16'(seq);
        return {s4, d4, q16[7:0], q16};
    endfunction

    task automatic drive_a(input logic [31:0] w);
        @(negedge clk);
        a_if.data_in  = w;
        a_if.valid_in = 1'b1;
    endtask

    task automatic drive_b(input logic [31:0] w);
        @(negedge clk);
        b_if.data_in  = w;
        b_if.valid_in = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            a_if.valid_in = 1'b0;
            b_if.valid_in = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a_if.valid_in = 1'b0;
        b_if.valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int bp_seq [8] = '{1, 2, 3, 4, 4, 5, 6, 7};
    bit bp_rdy [8] = '{1, 1, 1, 0, 1, 1, 1, 0};

    initial begin
        rst = 1'b1;
        a_if.data_in = '0; a_if.valid_in = 1'b0;
        b_if.data_in = '0; b_if.valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset a.rx_count",  a_rx, 0);
        check("reset a.ready_out", 32'(a_if.ready_out), 0);
        check("reset b.ready_out", 32'(b_if.ready_out), 0);
        check("reset a.done",      32'(a_done), 0);
        rst = 1'b0;

        // Back-pressure on dut_b: 3 high / 1 low, seq re-offered after a refusal.
        for (int i = 0; i < 8; i++) begin
            drive_b(pack(1, 5, bp_seq[i]));
            check($sformatf("bp b.ready_out[%0d]", i), 32'(b_if.ready_out), 32'(bp_rdy[i]));
        end
        idle(1);
        check("bp b.rx_count",  b_rx, 6);
        check("bp b.err_count", 32'(b_err), 0);
        check("bp b.done",      32'(b_done), 1);
        check("bp model rx",    m_rx[1], 6);

        // In-order on dut_a.
        for (int s = 1; s <= 5; s++) drive_a(pack(3, 5, s));
        idle(1);
        check("inorder rx_count",   a_rx, 5);
        check("inorder err_count",  32'(a_err), 0);
        check("inorder err_sticky", 32'(a_sticky), 0);
        check("inorder model rx",   m_rx[0], 5);

        // Mid-stream reset, then a fresh seq 37 seeds.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst rx_count",  a_rx, 0);
        check("midrst done",      32'(a_done), 0);
        check("midrst ready_out", 32'(a_if.ready_out), 0);
        check("midrst last_src",  32'(a_last), 0);
        rst = 1'b0;
        drive_a(pack(3, 5, 37));
        idle(1);
        check("seed37 seq_err",   32'(a_seqe), 0);
        check("seed37 err_count", 32'(a_err), 0);
        check("seed37 rx_count",  a_rx, 1);
        check("seed37 done",      32'(a_done), 1);

        // Gap: 1, 2, 4, 5.
        do_reset();
        drive_a(pack(3, 5, 1));
        drive_a(pack(3, 5, 2));
        drive_a(pack(3, 5, 4));
        drive_a(pack(3, 5, 5));
        check("gap seq_err pulse",  32'(a_seqe), 1);
        check("gap route_err",      32'(a_route), 0);
        check("gap last_err_src",   32'(a_last), 3);
        idle(1);
        check("gap seq5 seq_err",   32'(a_seqe), 0);
        check("gap err_count",      32'(a_err), 1);
        check("gap rx_count",       a_rx, 4);
        check("gap err_sticky",     32'(a_sticky), 1);
        check("gap model err",      32'(m_err[0]), 1);

        // Misroute leaves the table untouched.
        do_reset();
        drive_a(pack(2, 7, 1));
        drive_a(pack(2, 5, 1));
        check("misroute route_err", 32'(a_route), 1);
        check("misroute seq_err",   32'(a_seqe), 0);
        check("misroute err_count", 32'(a_err), 1);
        check("misroute last_src",  32'(a_last), 2);
        idle(1);
        check("reseed route_err",   32'(a_route), 0);
        check("reseed seq_err",     32'(a_seqe), 0);
        check("reseed err_count",   32'(a_err), 1);
        check("reseed rx_count",    a_rx, 2);

        // Sequence wrap mod 2^16.
        do_reset();
        drive_a(pack(9, 5, 16'hFFFE));
        drive_a(pack(9, 5, 16'hFFFF));
        drive_a(pack(9, 5, 16'h0000));
        idle(1);
        check("wrap err_count",  32'(a_err), 0);
        check("wrap rx_count",   a_rx, 3);
        check("wrap err_sticky", 32'(a_sticky), 0);

        // Interleaved sources with a duplicate on src 6.
        do_reset();
        drive_a(pack(4, 5, 10));
        drive_a(pack(6, 5, 100));
        drive_a(pack(4, 5, 11));
        drive_a(pack(6, 5, 100));
        drive_a(pack(4, 5, 12));
        check("dup seq_err pulse", 32'(a_seqe), 1);
        idle(1);
        check("dup err_count",     32'(a_err), 1);
        check("dup last_err_src",  32'(a_last), 6);
        check("dup rx_count",      a_rx, 5);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
